// File: rtl/router_link_pkg.sv
// Shared definitions for the router link egress/ingress paths:
// FSM state encoding, header field positions and the DW byte swap.
package router_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } egress_state_e;

  localparam int unsigned FMT_BIT     = 29;    // 1: 4-DW header, 0: 3-DW header
  localparam int unsigned PAYLOAD_BIT = 30;    // 1: payload follows the header
  localparam int unsigned LEN_MSB     = 9;     // length field is [LEN_MSB:0]
  localparam int unsigned MAX_LEN     = 1024;  // length 0 encodes this many DWs
  localparam int unsigned LEN_CNT_W   = 11;    // wide enough to hold MAX_LEN
  localparam int unsigned DW_W        = 32;

  // Host byte order <-> link byte order.
  function automatic logic [DW_W-1:0] byte_swap32(input logic [DW_W-1:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/link_byte_swap.sv
// Combinational DW byte swap shared by the ingress and egress link paths.
// Ports: dw (host-order DW in), swapped (link-order DW out).
module link_byte_swap
  import router_link_pkg::*;
(
  input  logic [DW_W-1:0] dw,
  output logic [DW_W-1:0] swapped
);

  assign swapped = byte_swap32(dw);

endmodule

// File: rtl/output_link_router_egress.sv
// Egress side of a router link: takes a 3/4-DW header plus an optional
// payload and serialises them, byte-swapped, onto a valid/ready link.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   header_in/valid/ready           128-bit header handshake (DW0 in [31:0])
//   payload_in/valid/ready          32-bit payload DW handshake
//   out_data/out_valid, link_ready  link output handshake (registered)
//   receive_link_input_buffer_full  stall request, freezes the egress path
//   out_parity                      XOR of out_data, only with EGRESS_DW_PARITY_EN
module output_link_router_egress
  import router_link_pkg::*;
#(
  parameter int LINK_NUMBER = 0,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [127:0]          header_in,
  input  logic                  header_valid,
  output logic                  header_ready,
  input  logic [DW_W-1:0]       payload_in,
  input  logic                  payload_valid,
  output logic                  payload_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  link_ready,
  input  logic                  receive_link_input_buffer_full
`ifdef EGRESS_DW_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  // LINK_NUMBER is identification only; only a 32-bit link is implemented.
  if (DATA_WIDTH != 32 || LINK_NUMBER < 0) begin : g_param_check
    $error("output_link_router_egress: unsupported DATA_WIDTH or LINK_NUMBER");
  end

  egress_state_e        state;
  logic [95:0]          hdr_tail;   // DW1..DW3 of the accepted header
  logic [1:0]           hdr_idx;    // next header DW to load
  logic                 hdr_four;
  logic                 has_pay;
  logic [LEN_CNT_W-1:0] pay_cnt;

  logic                 load_en;
  logic                 hdr_take;
  logic                 pay_take;
  logic                 hdr_last;
  logic [DW_W-1:0]      hdr_word;
  logic [DW_W-1:0]      swap_src;
  logic [DW_W-1:0]      swapped;
  logic [LEN_MSB:0]     len_field;

  // The output register may only be reloaded when not stalled and the link
  // slot is empty or being drained this cycle.
  assign load_en = !receive_link_input_buffer_full && (!out_valid || link_ready);

  // Readies are gated by rst_n so they drop immediately on reset assertion.
  assign header_ready  = rst_n && (state == ST_IDLE) && load_en;
  assign payload_ready = rst_n && (state == ST_PAY)  && load_en;
  assign hdr_take      = header_valid  && header_ready;
  assign pay_take      = payload_valid && payload_ready;

  assign hdr_last  = (hdr_idx == (hdr_four ? 2'd3 : 2'd2));
  assign len_field = header_in[LEN_MSB:0];

  // Select the latched header DW to send next.
  always_comb begin
    hdr_word = hdr_tail[31:0];
    case (hdr_idx)
      2'd2:    hdr_word = hdr_tail[63:32];
      2'd3:    hdr_word = hdr_tail[95:64];
      default: hdr_word = hdr_tail[31:0];
    endcase
  end

  // Source of the DW entering the swapper, by state.
  always_comb begin
    swap_src = header_in[31:0];
    case (state)
      ST_HDR:  swap_src = hdr_word;
      ST_PAY:  swap_src = payload_in;
      default: swap_src = header_in[31:0];
    endcase
  end

  link_byte_swap u_swap (
    .dw      (swap_src),
    .swapped (swapped)
  );

  // Packet FSM and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr_tail  <= '0;
      hdr_idx   <= '0;
      hdr_four  <= 1'b0;
      has_pay   <= 1'b0;
      pay_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_take) begin
            hdr_tail  <= header_in[127:32];
            hdr_four  <= header_in[FMT_BIT];
            has_pay   <= header_in[PAYLOAD_BIT];
            hdr_idx   <= 2'd1;
            if (!header_in[PAYLOAD_BIT]) begin
              pay_cnt <= '0;
            end else if (len_field == '0) begin
              pay_cnt <= LEN_CNT_W'(MAX_LEN);
            end else begin
              pay_cnt <= LEN_CNT_W'(len_field);
            end
            out_data  <= DATA_WIDTH'(swapped);
            out_valid <= 1'b1;
            state     <= ST_HDR;
          end else if (load_en) begin
            out_valid <= 1'b0;
          end
        end
        ST_HDR: begin
          if (load_en) begin
            out_data  <= DATA_WIDTH'(swapped);
            out_valid <= 1'b1;
            hdr_idx   <= hdr_idx + 2'd1;
            if (hdr_last) begin
              state <= has_pay ? ST_PAY : ST_IDLE;
            end
          end
        end
        ST_PAY: begin
          if (pay_take) begin
            out_data  <= DATA_WIDTH'(swapped);
            out_valid <= 1'b1;
            pay_cnt   <= pay_cnt - LEN_CNT_W'(1);
            if (pay_cnt == LEN_CNT_W'(1)) begin
              state <= ST_IDLE;
            end
          end else if (load_en) begin
            // Link took the DW and no payload is offered: emit a bubble.
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EGRESS_DW_PARITY_EN
  logic dw_load;

  assign dw_load = hdr_take || pay_take || ((state == ST_HDR) && load_en);

  // Even parity tracks out_data, loaded on the same edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (dw_load) begin
      out_parity <= ^swapped;
    end
  end
`endif

endmodule
